clock_monitor: RTL and testbench

CLOCK_MONITOR -- requirements
Module: clock_monitor

---
 rtl/clock_monitor_pkg.sv | 16 +
 rtl/clock_monitor_sync_edge_detect.sv | 30 +++
 rtl/clock_monitor.sv | 137 +++++++++++++
 tb/tb_clock_monitor.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/clock_monitor_pkg.sv
// Shared types and default constants for the clock monitor.
package clock_monitor_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ARM  = 2'd1,
    HIGH = 2'd2,
    LOW  = 2'd3
  } state_t;

  localparam int DEF_CNT_W    = 27;
  localparam int DEF_EXP_HIGH = 5;
  localparam int DEF_EXP_LOW  = 5;
  localparam int DEF_TOL      = 1;

endpackage

// File: rtl/clock_monitor_sync_edge_detect.sv
// Two-flop synchronizer plus history flop for the monitored clock.
// rise_det/fall_det are single-cycle pulses that reach the FSM on the
// third masterclock edge after the input changes.
module sync_edge_detect (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic rise_det,
  output logic fall_det
);

  logic sync1, sync2, hist;

  // Synchronizer chain followed by the history flop used for edge compare.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      hist  <= 1'b0;
    end else begin
      sync1 <= din;
      sync2 <= sync1;
      hist  <= sync2;
    end
  end

  assign rise_det = sync2 & ~hist;
  assign fall_det = ~sync2 & hist;

endmodule

// File: rtl/clock_monitor.sv
// Measures high and low time of clk_in in masterclock cycles and flags
// periods outside tolerance or phases that never end.
//
//   state | meaning
//   IDLE  | disabled, waiting for enable
//   ARM   | enabled, waiting for the first rising edge
//   HIGH  | counting the high phase
//   LOW   | counting the low phase; next rise publishes the period
module clock_monitor
  import clock_monitor_pkg::*;
#(
  parameter int CNT_W    = DEF_CNT_W,
  parameter int EXP_HIGH = DEF_EXP_HIGH,
  parameter int EXP_LOW  = DEF_EXP_LOW,
  parameter int TOL      = DEF_TOL
) (
  input  logic             masterclock,
  input  logic             reset_n,
  input  logic             clk_in,
  input  logic             enable,
  output logic [CNT_W-1:0] high_cnt,
  output logic [CNT_W-1:0] low_cnt,
  output logic             meas_valid,
  output logic             freq_ok,
  output logic             timeout
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic signed [CNT_W:0] EXP_H_S = (CNT_W+1)'(EXP_HIGH);
  localparam logic signed [CNT_W:0] EXP_L_S = (CNT_W+1)'(EXP_LOW);
  localparam logic signed [CNT_W:0] TOL_S   = (CNT_W+1)'(TOL);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, hreg;
  logic             rise_det, fall_det;
  logic             cnt_load, cnt_inc, cap_high, publish, sat;
  logic signed [CNT_W:0] high_dev, low_dev;
  logic             high_in, low_in;

  sync_edge_detect u_sync (
    .clk      (masterclock),
    .rst_n    (reset_n),
    .din      (clk_in),
    .rise_det (rise_det),
    .fall_det (fall_det)
  );

  // The high phase is already in hreg; the low phase is still live in cnt
  // at the moment the closing rise is seen.
  assign high_dev = $signed({1'b0, hreg}) - EXP_H_S;
  assign low_dev  = $signed({1'b0, cnt}) - EXP_L_S;
  assign high_in  = (high_dev <= TOL_S) && (high_dev >= -TOL_S);
  assign low_in   = (low_dev <= TOL_S) && (low_dev >= -TOL_S);

  // State register.
  always_ff @(posedge masterclock or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  // Next state and datapath controls; a low enable overrides every edge event.
  always_comb begin
    state_nxt = state;
    cnt_load  = 1'b0;
    cnt_inc   = 1'b0;
    cap_high  = 1'b0;
    publish   = 1'b0;
    sat       = 1'b0;
    if (!enable) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE: state_nxt = ARM;
        ARM: begin
          if (rise_det) begin
            cnt_load  = 1'b1;
            state_nxt = HIGH;
          end
        end
        HIGH: begin
          if (fall_det) begin
            cap_high  = 1'b1;
            cnt_load  = 1'b1;
            state_nxt = LOW;
          end else if (cnt == CNT_MAX) begin
            sat       = 1'b1;
            state_nxt = ARM;
          end else begin
            cnt_inc = 1'b1;
          end
        end
        LOW: begin
          if (rise_det) begin
            publish   = 1'b1;
            cnt_load  = 1'b1;
            state_nxt = HIGH;
          end else if (cnt == CNT_MAX) begin
            sat       = 1'b1;
            state_nxt = ARM;
          end else begin
            cnt_inc = 1'b1;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Phase counter, captured high time and registered results.
  always_ff @(posedge masterclock or negedge reset_n) begin
    if (!reset_n) begin
      cnt        <= '0;
      hreg       <= '0;
      high_cnt   <= '0;
      low_cnt    <= '0;
      meas_valid <= 1'b0;
      freq_ok    <= 1'b0;
      timeout    <= 1'b0;
    end else begin
      meas_valid <= publish;
      if (cnt_load)     cnt <= CNT_ONE;
      else if (cnt_inc) cnt <= cnt + 1'b1;
      if (cap_high) hreg <= cnt;
      if (publish) begin
        high_cnt <= hreg;
        low_cnt  <= cnt;
        freq_ok  <= high_in && low_in;
        timeout  <= 1'b0;
      end else if (sat) begin
        timeout <= 1'b1;
        freq_ok <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_clock_monitor.sv
// Self-checking bench for clock_monitor: drives clk_in as sequences of
// high/low phase lengths and predicts one result per completed period.
module tb_clock_monitor;
  import clock_monitor_pkg::*;

  localparam int EXP_H = 5;
  localparam int EXP_L = 5;
  localparam int TOLB  = 1;

  logic        masterclock = 1'b0;
  logic        reset_n = 1'b0;
  logic        clk_in = 1'b0;
  logic        enable = 1'b0;
  logic        enable4 = 1'b0;
  logic [26:0] high_cnt, low_cnt;
  logic        meas_valid, freq_ok, timeout;
  logic [3:0]  high_cnt4, low_cnt4;
  logic        meas_valid4, freq_ok4, timeout4;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int last_valid_cyc = -1;
  int valid_gap = 0;
  int target = 0;
  int last_h = 0, last_l = 0;
  bit last_ok = 1'b0;

  typedef struct {int h; int l; bit ok;} meas_t;
  meas_t exp_q[$];
  meas_t exp4_q[$];

  always #5 masterclock = ~masterclock;

  clock_monitor dut (
    .masterclock (masterclock), .reset_n (reset_n), .clk_in (clk_in),
    .enable (enable), .high_cnt (high_cnt), .low_cnt (low_cnt),
    .meas_valid (meas_valid), .freq_ok (freq_ok), .timeout (timeout)
  );

  clock_monitor #(.CNT_W(4)) dut4 (
    .masterclock (masterclock), .reset_n (reset_n), .clk_in (clk_in),
    .enable (enable4), .high_cnt (high_cnt4), .low_cnt (low_cnt4),
    .meas_valid (meas_valid4), .freq_ok (freq_ok4), .timeout (timeout4)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  function automatic bit in_tol(input int v, input int e);
    return (v - e <= TOLB) && (e - v <= TOLB);
  endfunction

  task automatic cycles(input int n);
    repeat (n) @(negedge masterclock);
  endtask

  task automatic push_period(input int h, input int l);
    meas_t m;
    m.h = h;
    m.l = l;
    m.ok = in_tol(h, EXP_H) && in_tol(l, EXP_L);
    if (target == 0) exp_q.push_back(m);
    else             exp4_q.push_back(m);
    last_h = h;
    last_l = l;
    last_ok = m.ok;
  endtask

  // n full periods (fh/fl of 0 means random 2..9), then a closing rise held high.
  task automatic run_periods(input int n, input int fh, input int fl);
    int h, l;
    for (int k = 0; k < n; k++) begin
      h = (fh != 0) ? fh : int'($urandom_range(2, 9));
      l = (fl != 0) ? fl : int'($urandom_range(2, 9));
      clk_in = 1'b1;
      cycles(h);
      clk_in = 1'b0;
      cycles(l);
      push_period(h, l);
    end
    clk_in = 1'b1;
    cycles(6);
  endtask

  task automatic restart(input int t);
    enable = 1'b0;
    enable4 = 1'b0;
    clk_in = 1'b0;
    cycles(6);
    target = t;
    if (t == 0) enable = 1'b1;
    else        enable4 = 1'b1;
    cycles(3);
  endtask

  // Result monitor: every meas_valid must match the oldest predicted period.
  always @(posedge masterclock) begin
    meas_t m;
    cyc++;
    #1;
    if (meas_valid === 1'b1) begin
      if (exp_q.size() == 0) chk("unexpected_meas_valid", meas_valid, 0);
      else begin
        m = exp_q.pop_front();
        chk("high_cnt", high_cnt, m.h);
        chk("low_cnt", low_cnt, m.l);
        chk("freq_ok", freq_ok, m.ok);
        chk("timeout_at_valid", timeout, 0);
      end
      if (last_valid_cyc >= 0) valid_gap = cyc - last_valid_cyc;
      last_valid_cyc = cyc;
    end
    if (meas_valid4 === 1'b1) begin
      if (exp4_q.size() == 0) chk("unexpected_meas_valid4", meas_valid4, 0);
      else begin
        m = exp4_q.pop_front();
        chk("high_cnt4", high_cnt4, m.h);
        chk("low_cnt4", low_cnt4, m.l);
        chk("freq_ok4", freq_ok4, m.ok);
        chk("timeout4_at_valid", timeout4, 0);
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    cycles(2);
    chk("rst_high_cnt", high_cnt, 0);
    chk("rst_low_cnt", low_cnt, 0);
    chk("rst_meas_valid", meas_valid, 0);
    chk("rst_freq_ok", freq_ok, 0);
    chk("rst_timeout", timeout, 0);
    chk("rst_state", dut.state, IDLE);
    reset_n = 1'b1;

    // Nominal 5/5 clock: results every 10 cycles.
    restart(0);
    run_periods(4, 5, 5);
    chk("valid_gap_5_5", valid_gap, 10);

    // Out-of-tolerance and edge-of-tolerance periods.
    restart(0);
    run_periods(1, 7, 5);
    chk("freq_ok_7_5", freq_ok, 0);
    restart(0);
    run_periods(1, 6, 4);
    chk("freq_ok_6_4", freq_ok, 1);

    // Random phase lengths.
    restart(0);
    run_periods(10, 0, 0);
    restart(0);
    run_periods(10, 0, 0);

    // Disable during LOW: nothing published, outputs hold, clean re-arm.
    restart(0);
    run_periods(1, 6, 4);
    clk_in = 1'b0;
    cycles(4);
    chk("state_low_before_disable", dut.state, LOW);
    enable = 1'b0;
    cycles(4);
    clk_in = 1'b1;
    cycles(6);
    clk_in = 1'b0;
    cycles(3);
    chk("hold_high_cnt", high_cnt, last_h);
    chk("hold_low_cnt", low_cnt, last_l);
    chk("hold_freq_ok", freq_ok, last_ok);
    chk("state_idle_disabled", dut.state, IDLE);
    enable = 1'b1;
    cycles(3);
    run_periods(2, 5, 5);

    // Disable coinciding with the closing rise in LOW.
    restart(0);
    clk_in = 1'b1;
    cycles(5);
    clk_in = 1'b0;
    cycles(5);
    clk_in = 1'b1;
    cycles(2);
    chk("state_low_at_rise", dut.state, LOW);
    enable = 1'b0;
    @(posedge masterclock);
    #2;
    chk("state_idle_after_rise", dut.state, IDLE);
    chk("no_valid_on_disable", meas_valid, 0);
    cycles(4);

    // Saturation on the 4-bit instance.
    restart(1);
    run_periods(2, 5, 5);
    cycles(4);
    chk("timeout4_not_yet", timeout4, 0);
    cycles(15);
    chk("timeout4_set", timeout4, 1);
    chk("freq_ok4_cleared", freq_ok4, 0);
    chk("high_cnt4_hold", high_cnt4, 5);
    chk("low_cnt4_hold", low_cnt4, 5);
    chk("state4_arm", dut4.state, ARM);
    clk_in = 1'b0;
    cycles(4);
    run_periods(1, 5, 5);
    chk("timeout4_cleared", timeout4, 0);

    // Asynchronous reset in the middle of a HIGH phase.
    restart(0);
    run_periods(3, 0, 0);
    chk("queue_drained_pre_reset", exp_q.size(), 0);
    @(posedge masterclock);
    #2;
    reset_n = 1'b0;
    #1;
    chk("async_high_cnt", high_cnt, 0);
    chk("async_low_cnt", low_cnt, 0);
    chk("async_freq_ok", freq_ok, 0);
    chk("async_high_cnt4", high_cnt4, 0);
    chk("async_state", dut.state, IDLE);
    #1;
    reset_n = 1'b1;
    @(posedge masterclock);
    #1;
    chk("first_edge_after_reset", dut.state, ARM);
    restart(0);
    run_periods(3, 0, 0);

    cycles(10);
    chk("exp_q_empty", exp_q.size(), 0);
    chk("exp4_q_empty", exp4_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
